// File: rtl/stream_pkt_arbiter.sv
// Packet-atomic round-robin arbiter: N AXI-Stream sources share one sink, with
// per-beat source tagging and optional truncation of over-long packets.
module stream_pkt_arbiter #(
    parameter int NUM_IN        = 4,
    parameter int DATA_WIDTH    = 32,
    parameter int USER_WIDTH    = 33,
    parameter int MAX_PKT_BEATS = 4,
    parameter int ID_WIDTH      = $clog2(NUM_IN)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NUM_IN*DATA_WIDTH-1:0]   s_data,
    input  logic [NUM_IN*DATA_WIDTH/8-1:0] s_keep,
    input  logic [NUM_IN*USER_WIDTH-1:0]   s_user,
    input  logic [NUM_IN-1:0]              s_last,
    input  logic [NUM_IN-1:0]              s_valid,
    output logic [NUM_IN-1:0]              s_ready,
    output logic [DATA_WIDTH-1:0]          m_data,
    output logic [DATA_WIDTH/8-1:0]        m_keep,
    output logic [USER_WIDTH-1:0]          m_user,
    output logic                           m_last,
    output logic                           m_valid,
    input  logic                           m_ready,
    output logic [ID_WIDTH-1:0]            m_id,
    output logic                           trunc_err,
    output logic [15:0]                    trunc_count
);

    localparam int KEEP_W = DATA_WIDTH / 8;
    localparam int CNT_W  = (MAX_PKT_BEATS > 0) ? $clog2(MAX_PKT_BEATS + 1) : 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_PASS,
        ST_DROP
    } state_t;

    state_t              state_q, state_d;
    logic [ID_WIDTH-1:0] grant_q, grant_d;
    logic [ID_WIDTH-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0]    beat_cnt_q, beat_cnt_d;
    logic                trunc_err_q, trunc_err_d;
    logic [15:0]         trunc_count_q, trunc_count_d;

    logic [DATA_WIDTH-1:0] lane_data;
    logic [KEEP_W-1:0]     lane_keep;
    logic [USER_WIDTH-1:0] lane_user;
    logic                  lane_last;
    logic                  lane_valid;
    logic [NUM_IN-1:0]     grant_oh;

    logic [ID_WIDTH-1:0] hi_sel, lo_sel, sel;
    logic                hi_found, lo_found;
    logic [ID_WIDTH-1:0] next_ptr;
    logic                force_last;

    always_comb begin
        lane_data  = '0;
        lane_keep  = '0;
        lane_user  = '0;
        lane_last  = 1'b0;
        lane_valid = 1'b0;
        grant_oh   = '0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (ID_WIDTH'(i) == grant_q) begin
                lane_data   = s_data[i*DATA_WIDTH +: DATA_WIDTH];
                lane_keep   = s_keep[i*KEEP_W +: KEEP_W];
                lane_user   = s_user[i*USER_WIDTH +: USER_WIDTH];
                lane_last   = s_last[i];
                lane_valid  = s_valid[i];
                grant_oh[i] = 1'b1;
            end
        end
    end

    // Rotating priority: first requester at or above rr_ptr, else lowest overall.
    always_comb begin
        hi_sel   = '0;
        lo_sel   = '0;
        hi_found = 1'b0;
        lo_found = 1'b0;
        for (int unsigned i = 0; i < NUM_IN; i++) begin
            if (!hi_found && s_valid[i] && (ID_WIDTH'(i) >= rr_ptr_q)) begin
                hi_found = 1'b1;
                hi_sel   = ID_WIDTH'(i);
            end
            if (!lo_found && s_valid[i]) begin
                lo_found = 1'b1;
                lo_sel   = ID_WIDTH'(i);
            end
        end
        sel = hi_found ? hi_sel : lo_sel;
    end

    assign next_ptr   = (grant_q == ID_WIDTH'(NUM_IN - 1)) ? '0 : grant_q + ID_WIDTH'(1);
    assign force_last = (MAX_PKT_BEATS != 0) && (beat_cnt_q == CNT_W'(MAX_PKT_BEATS - 1));

    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        rr_ptr_d      = rr_ptr_q;
        beat_cnt_d    = beat_cnt_q;
        trunc_err_d   = 1'b0;
        trunc_count_d = trunc_count_q;
        m_valid       = 1'b0;
        m_last        = 1'b0;
        s_ready       = '0;

        case (state_q)
            ST_IDLE: begin
                if (|s_valid) begin
                    grant_d    = sel;
                    beat_cnt_d = '0;
                    state_d    = ST_PASS;
                end
            end
            ST_PASS: begin
                m_valid = lane_valid;
                m_last  = lane_last | force_last;
                s_ready = grant_oh & {NUM_IN{m_ready}};
                if (lane_valid && m_ready) begin
                    if (MAX_PKT_BEATS != 0) begin
                        beat_cnt_d = beat_cnt_q + CNT_W'(1);
                    end
                    // A natural last on the limit beat wins over truncation.
                    if (lane_last) begin
                        state_d  = ST_IDLE;
                        rr_ptr_d = next_ptr;
                    end else if (force_last) begin
                        trunc_err_d = 1'b1;
                        if (trunc_count_q != 16'hFFFF) begin
                            trunc_count_d = trunc_count_q + 16'd1;
                        end
                        state_d = ST_DROP;
                    end
                end
            end
            ST_DROP: begin
                s_ready = grant_oh;
                if (lane_valid && lane_last) begin
                    state_d  = ST_IDLE;
                    rr_ptr_d = next_ptr;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            rr_ptr_q      <= '0;
            beat_cnt_q    <= '0;
            trunc_err_q   <= 1'b0;
            trunc_count_q <= '0;
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            rr_ptr_q      <= rr_ptr_d;
            beat_cnt_q    <= beat_cnt_d;
            trunc_err_q   <= trunc_err_d;
            trunc_count_q <= trunc_count_d;
        end
    end

    assign m_data      = lane_data;
    assign m_keep      = lane_keep;
    assign m_user      = lane_user;
    assign m_id        = grant_q;
    assign trunc_err   = trunc_err_q;
    assign trunc_count = trunc_count_q;

endmodule

// File: tb/tb_stream_pkt_arbiter.sv
// Bench for stream_pkt_arbiter: source queues feed the DUT, a scoreboard holds
// the expected output beats in order and is checked on every accepted beat.
module tb_stream_pkt_arbiter;

    localparam int N    = 4;
    localparam int DW   = 32;
    localparam int UW   = 33;
    localparam int KW   = DW / 8;
    localparam int MAXB = 4;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [N*DW-1:0]   s_data;
    logic [N*KW-1:0]   s_keep;
    logic [N*UW-1:0]   s_user;
    logic [N-1:0]      s_last;
    logic [N-1:0]      s_valid;
    logic [N-1:0]      s_ready;
    logic [DW-1:0]     m_data;
    logic [KW-1:0]     m_keep;
    logic [UW-1:0]     m_user;
    logic              m_last;
    logic              m_valid;
    logic              m_ready;
    logic [IDW-1:0]    m_id;
    logic              trunc_err;
    logic [15:0]       trunc_count;

    always #5 clk = ~clk;

    stream_pkt_arbiter #(
        .NUM_IN(N), .DATA_WIDTH(DW), .USER_WIDTH(UW), .MAX_PKT_BEATS(MAXB)
    ) dut (
        .clk(clk), .rst(rst),
        .s_data(s_data), .s_keep(s_keep), .s_user(s_user), .s_last(s_last),
        .s_valid(s_valid), .s_ready(s_ready),
        .m_data(m_data), .m_keep(m_keep), .m_user(m_user), .m_last(m_last),
        .m_valid(m_valid), .m_ready(m_ready), .m_id(m_id),
        .trunc_err(trunc_err), .trunc_count(trunc_count)
    );

    typedef struct {
        logic [IDW-1:0] id;
        logic [DW-1:0]  data;
        logic [KW-1:0]  keep;
        logic [UW-1:0]  user;
        logic           last;
    } beat_t;

    typedef struct {
        int unsigned src;
        int unsigned nbeats;
        int unsigned ntrunc;
    } vec_t;

    beat_t       src_q [N][$];
    beat_t       sb[$];
    int          errors = 0;
    int          checks = 0;
    int          terr_seen = 0;
    bit          bp_en = 1'b0;
    int unsigned pkt_seq = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic send_pkt(input int unsigned src, input int unsigned n);
        for (int unsigned b = 0; b < n; b++) begin
            beat_t bt;
            beat_t e;
            bt.id   = IDW'(src);
            bt.data = {8'(src), 8'(pkt_seq), 16'(b)};
            bt.keep = KW'($urandom());
            bt.user = UW'({$urandom(), $urandom()});
            bt.last = (b == n - 1);
            src_q[src].push_back(bt);
            if (b < MAXB) begin
                e      = bt;
                e.last = bt.last || (b == MAXB - 1);
                sb.push_back(e);
            end
        end
        pkt_seq++;
    endtask

    task automatic wait_done();
        int unsigned cyc = 0;
        bit busy;
        do begin
            @(negedge clk); #2;
            busy = (sb.size() != 0);
            for (int i = 0; i < N; i++) busy |= (src_q[i].size() != 0);
            cyc++;
        end while (busy && cyc < 500);
        chk("traffic_done_timeout", 64'(busy), 64'd0);
        repeat (3) @(negedge clk);
        #2;
    endtask

    task automatic reset_vals(input string tag);
        chk({tag, "_m_valid"}, 64'(m_valid), 64'd0);
        chk({tag, "_s_ready"}, 64'(s_ready), 64'd0);
        chk({tag, "_m_last"}, 64'(m_last), 64'd0);
        chk({tag, "_m_id"}, 64'(m_id), 64'd0);
        chk({tag, "_trunc_err"}, 64'(trunc_err), 64'd0);
        chk({tag, "_trunc_count"}, 64'(trunc_count), 64'd0);
    endtask

    // Source drivers and output monitor
    initial begin : bfm
        logic [N-1:0] acc;
        logic [N-1:0] exp_rdy;
        bit           stall_prev;
        beat_t        held;
        beat_t        e;
        s_data = '0; s_keep = '0; s_user = '0; s_last = '0; s_valid = '0;
        m_ready = 1'b1;
        stall_prev = 1'b0;
        forever begin
            @(negedge clk);
            acc = s_valid & s_ready;
            if (rst) begin
                if (trunc_err) terr_seen++;
                if (stall_prev) begin
                    chk("hold_valid", 64'(m_valid), 64'd1);
                    chk("hold_data", 64'(m_data), 64'(held.data));
                    chk("hold_last", 64'(m_last), 64'(held.last));
                    chk("hold_id", 64'(m_id), 64'(held.id));
                end
                if (m_valid) begin
                    exp_rdy = '0;
                    exp_rdy[m_id] = m_ready;
                    chk("s_ready_mirror", 64'(s_ready), 64'(exp_rdy));
                    if (m_ready) begin
                        if (sb.size() == 0) begin
                            chk("sb_unexpected_beat", 64'(m_data), 64'd0);
                            errors++;
                        end else begin
                            e = sb.pop_front();
                            chk("beat_id", 64'(m_id), 64'(e.id));
                            chk("beat_data", 64'(m_data), 64'(e.data));
                            chk("beat_keep", 64'(m_keep), 64'(e.keep));
                            chk("beat_user", 64'(m_user), 64'(e.user));
                            chk("beat_last", 64'(m_last), 64'(e.last));
                        end
                    end
                end
                stall_prev = m_valid && !m_ready;
                held.data = m_data; held.last = m_last; held.id = m_id;
            end else begin
                stall_prev = 1'b0;
            end
            @(posedge clk); #1;
            for (int i = 0; i < N; i++) begin
                if (acc[i] && src_q[i].size() > 0) void'(src_q[i].pop_front());
                if (src_q[i].size() > 0) begin
                    s_valid[i]            = 1'b1;
                    s_last[i]             = src_q[i][0].last;
                    s_data[i*DW +: DW]    = src_q[i][0].data;
                    s_keep[i*KW +: KW]    = src_q[i][0].keep;
                    s_user[i*UW +: UW]    = src_q[i][0].user;
                end else begin
                    s_valid[i] = 1'b0;
                    s_last[i]  = 1'b0;
                end
            end
            m_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    initial begin : watchdog
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : main
        vec_t  vecs[6];
        int    exp_tc;
        int    terr_before;
        beat_t hold;

        vecs[0] = '{src: 2, nbeats: 3, ntrunc: 0};
        vecs[1] = '{src: 1, nbeats: 6, ntrunc: 1};
        vecs[2] = '{src: 0, nbeats: 4, ntrunc: 0};
        vecs[3] = '{src: 3, nbeats: 1, ntrunc: 0};
        vecs[4] = '{src: 2, nbeats: 5, ntrunc: 1};
        vecs[5] = '{src: 1, nbeats: 8, ntrunc: 1};

        rst = 1'b0;
        repeat (3) @(negedge clk);
        reset_vals("reset");
        #2 rst = 1'b1;
        exp_tc = 0;

        for (int v = 0; v < 6; v++) begin
            terr_before = terr_seen;
            exp_tc += int'(vecs[v].ntrunc);
            send_pkt(vecs[v].src, vecs[v].nbeats);
            wait_done();
            chk("vec_trunc_count", 64'(trunc_count), 64'(exp_tc));
            chk("vec_trunc_err_pulses", 64'(terr_seen - terr_before), 64'(vecs[v].ntrunc));
        end

        // Round robin from a fresh reset: expected order 0,1,2,3,0
        @(negedge clk); #2 rst = 1'b0;
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        exp_tc = 0;
        send_pkt(0, 2); send_pkt(1, 2); send_pkt(2, 2); send_pkt(3, 2); send_pkt(0, 2);
        wait_done();
        chk("rr_trunc_count", 64'(trunc_count), 64'd0);

        // Backpressure on source 3 traffic
        bp_en = 1'b1;
        terr_before = terr_seen;
        send_pkt(3, 3); send_pkt(3, 2); send_pkt(3, 4); send_pkt(3, 6);
        wait_done();
        bp_en = 1'b0;
        wait_done();
        chk("bp_trunc_count", 64'(trunc_count), 64'd1);
        chk("bp_trunc_err_pulses", 64'(terr_seen - terr_before), 64'd1);

        // Reset mid-packet: rr_ptr is 2 before the interrupted packet
        send_pkt(1, 2);
        wait_done();
        send_pkt(1, 4);
        hold = sb[1];
        repeat (3) void'(sb.pop_back());
        begin
            int unsigned cyc = 0;
            do begin
                @(negedge clk); #2;
                cyc++;
            end while (sb.size() != 0 && cyc < 100);
            chk("midrst_first_beat_timeout", 64'(sb.size()), 64'd0);
        end
        @(posedge clk); #2;
        chk("midrst_beat2_valid", 64'(m_valid), 64'd1);
        chk("midrst_beat2_data", 64'(m_data), 64'(hold.data));
        chk("midrst_beat2_id", 64'(m_id), 64'd1);
        rst = 1'b0;
        #1;
        reset_vals("midrst");
        src_q[1].delete();
        repeat (2) @(negedge clk);
        #2 rst = 1'b1;
        send_pkt(0, 2); send_pkt(3, 2);
        wait_done();
        chk("post_rst_trunc_count", 64'(trunc_count), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stream_pkt_arbiter.md
# stream_pkt_arbiter

Packet-atomic round-robin arbiter that shares one AXI-Stream sink (typically a `stream_fifo` input) between `NUM_IN` stream sources. A grant is held from the first beat to the `last` beat of a packet, so packets are never interleaved. Each output beat is tagged with its source index. Packets longer than `MAX_PKT_BEATS` are truncated: a forced `last` is emitted and the remainder of that packet is drained and discarded. The block sits between the requesting AXI-Stream masters and the shared FIFO/datapath.

## Interface
- `NUM_IN`, 4: number of requesters, 2..16.
- `DATA_WIDTH`, 32: data bits per beat; keep width is `DATA_WIDTH/8`.
- `USER_WIDTH`, 33: user bits per beat.
- `MAX_PKT_BEATS`, 4: beat limit per packet; 0 disables truncation.
- `ID_WIDTH`, `$clog2(NUM_IN)`: derived; do not override.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `s_data`  in  `NUM_IN*DATA_WIDTH`  source data; lane i at `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `s_keep`  in  `NUM_IN*DATA_WIDTH/8`  source keep, packed the same way.
- `s_user`  in  `NUM_IN*USER_WIDTH`  source user, packed the same way.
- `s_last`  in  `NUM_IN`  per-source last.
- `s_valid`  in  `NUM_IN`  per-source valid.
- `s_ready`  out  `NUM_IN`  per-source ready.
- `m_data`, `m_keep`, `m_user`  out  as above, one lane  granted beat.
- `m_last`  out  1  last; forced high on a truncated beat.
- `m_valid`  out  1  output valid.
- `m_ready`  in  1  sink ready.
- `m_id`  out  `ID_WIDTH`  index of the granted source; stable for the whole packet.
- `trunc_err`  out  1  one-cycle pulse when a truncation is forced.
- `trunc_count`  out  16  saturating count of truncated packets.

## Operation
- FSM states:
  - IDLE: no grant; all `s_ready`=0; `m_valid`=0. If any `s_valid` is high, select the first set bit searching from `rr_ptr` upward with wrap. Register it into `grant`, clear `beat_cnt`, and go to PASS.
  - PASS: `m_*` = lane `grant`; `m_valid` = `s_valid[grant]`; `s_ready[grant]` = `m_ready`; other `s_ready` = 0. A beat is accepted when `m_valid && m_ready`. On each accepted beat, `beat_cnt` increments.
    - If `s_last[grant]` is set on the accepted beat: go to IDLE and set `rr_ptr` = `grant+1` mod `NUM_IN`.
    - Else, if `MAX_PKT_BEATS`≠0 and `beat_cnt`==`MAX_PKT_BEATS-1`: drive `m_last`=1 on that beat, pulse `trunc_err`, increment `trunc_count` (saturating at 0xFFFF), and go to DROP.
  - DROP: `m_valid`=0; `s_ready[grant]`=1; other `s_ready`=0. Beats from `grant` are discarded. When a beat with `s_last[grant]` is consumed, go to IDLE and advance `rr_ptr` as in PASS.
- `m_id` = `grant` in every state; it is meaningful only while `m_valid`.
- Keep and user pass through unmodified, including on the forced-last beat.
- A packet whose natural `last` falls exactly on beat `MAX_PKT_BEATS` is not a truncation: no `trunc_err`, next state IDLE.
- `beat_cnt` width is `$clog2(MAX_PKT_BEATS+1)`; it never exceeds `MAX_PKT_BEATS-1` in PASS.

## Timing
- Reset values (async assert, sync release): state IDLE, `grant`=0, `rr_ptr`=0, `beat_cnt`=0, `s_ready`=0, `m_valid`=0, `m_last`=0, `m_id`=0, `trunc_err`=0, `trunc_count`=0.
- Arbitration costs one cycle: the first beat of a packet can be accepted at the earliest one cycle after the IDLE cycle that saw `s_valid`. Each packet incurs one bubble cycle.
- The PASS datapath is combinational from source to sink. Latency is 0 cycles, throughput is 1 beat/cycle, and `m_ready`→`s_ready` is a combinational path.
- AXI-Stream rules hold on `m_*`: once `m_valid` is high, it and `m_data/keep/user/last/id` stay stable until accepted. This relies on the sources obeying the same rule, since the grant cannot change mid-packet.
- `trunc_err` is asserted in the cycle after the forced-last beat is accepted, for one cycle.
- Simultaneous requests in IDLE: the lowest index at or above `rr_ptr` wins, with wraparound past `NUM_IN-1` to 0.
- If `rst` asserts mid-packet, state is lost immediately. Outputs drop to reset values. No recovery of the partial packet is attempted.

## Test plan
- Single source 2, 3-beat packet with `m_ready`=1 -> IDLE 1 cycle, 3 beats out with `m_id`=2, `m_last` on beat 3, `trunc_err`=0, next `rr_ptr`=3.
- All 4 sources valid with 2-beat packets after reset -> output order 0,1,2,3,0 with `m_id` constant within each packet and no interleaving.
- Source 1, 6-beat packet, `MAX_PKT_BEATS`=4 -> 4 beats out with forced `m_last` on beat 4, beats 5-6 consumed with `m_valid`=0, `trunc_err` pulses once, `trunc_count`=1.
- Source 0, exactly 4-beat packet, `MAX_PKT_BEATS`=4 -> 4 beats out, natural last, `trunc_err`=0, `trunc_count` unchanged.
- Random `m_ready` backpressure at 50% on source 3 traffic -> data and `m_last` held stable while `m_valid && !m_ready`, `s_ready[3]` mirrors `m_ready`, no beat lost or duplicated.
- `rst` low during beat 2 of a 4-beat packet -> all outputs return to reset values asynchronously; after release, the next grant starts from source 0.
